crc_frame_tx: RTL



---
 rtl/crc_net_pkg.sv | 25 ++
 rtl/crc_serial.sv | 62 ++++++
 rtl/crc_frame_tx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_net_pkg.sv
// ---------------------------------------------------------------------------
// crc_net_pkg
// Definitions shared by the CRC framed-line transmitter and, later, the
// matching receiver:
//   crc_state_e   : frame sequencer states (IDLE, PRE, LEN, DATA, CRC, STOP)
//   LEN_W         : width of the length field carried on the line
//   *_DEF         : default sync byte, generator polynomial and CRC seed
// ---------------------------------------------------------------------------
package crc_net_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CRC  = 3'd4,
        STOP = 3'd5
    } crc_state_e;

    localparam int         LEN_W        = 8;
    localparam logic [7:0] PREAMBLE_DEF = 8'hA5;
    localparam logic [7:0] CRC_POLY_DEF = 8'h07;
    localparam logic [7:0] CRC_INIT_DEF = 8'h00;

endpackage

// File: rtl/crc_serial.sv
// ---------------------------------------------------------------------------
// crc_serial
// Bit-serial MSB-first CRC register (implicit top bit, no reflection, no
// final XOR). Shared between the transmitter and the future receiver.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (register -> INIT)
//   init       : reseed the register with INIT
//   en         : absorb din this cycle; when init is also high the bit is
//                absorbed into the fresh seed rather than the old value
//   din        : message bit
//   crc        : registered CRC value
// ---------------------------------------------------------------------------
module crc_serial
    import crc_net_pkg::*;
#(
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC_POLY_DEF),
    parameter logic [CRC_W-1:0] INIT  = CRC_W'(CRC_INIT_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_r;
    logic [CRC_W-1:0] base_s;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] cur,
                                                  input logic             b);
        logic fb;
        fb       = cur[CRC_W-1] ^ b;
        crc_step = (cur << 1) ^ (fb ? POLY : {CRC_W{1'b0}});
    endfunction

    // Select the value the next bit is folded into.
    always_comb begin
        if (init) begin
            base_s = INIT;
        end else begin
            base_s = crc_r;
        end
    end

    // CRC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= INIT;
        end else if (en) begin
            crc_r <= crc_step(base_s, din);
        end else if (init) begin
            crc_r <= INIT;
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/crc_frame_tx.sv
// ---------------------------------------------------------------------------
// crc_frame_tx
// Buffers payload bytes, then on start sends one frame on a single line:
// PREAMBLE, length L, L payload bytes, CRC (over length + payload), followed
// by a 2-bit-period high stop interval. Every field goes out MSB first and
// each bit is held CLKS_PER_BIT clocks.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/in_data : payload byte offer; in_ready accepts (combinational)
//   start            : launch a frame (only honoured in IDLE with data)
//   test_mode        : captured at start; inverts the transmitted CRC LSB
//   tx_line          : registered serial line, idles high
//   busy             : frame in progress
//   done             : one-cycle pulse in the last stop cycle
//   byte_count       : bytes currently buffered
// ---------------------------------------------------------------------------
module crc_frame_tx
    import crc_net_pkg::*;
#(
    parameter int               DATA_W       = 8,
    parameter int               MAX_BYTES    = 16,
    parameter int               CRC_W        = 8,
    parameter logic [CRC_W-1:0] CRC_POLY     = CRC_W'(CRC_POLY_DEF),
    parameter logic [CRC_W-1:0] CRC_INIT     = CRC_W'(CRC_INIT_DEF),
    parameter int               CLKS_PER_BIT = 4,
    parameter logic [7:0]       PREAMBLE     = PREAMBLE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              start,
    input  logic              test_mode,
    output logic              tx_line,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  byte_count
);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_PRE  = PRE;
    localparam logic [2:0] ST_LEN  = LEN;
    localparam logic [2:0] ST_DATA = DATA;
    localparam logic [2:0] ST_CRC  = CRC;
    localparam logic [2:0] ST_STOP = STOP;

    // The shift register holds the field being sent, left aligned.
    localparam int SR_W  = (CRC_W > 8) ? CRC_W : 8;
    localparam int BIT_W = $clog2(SR_W);
    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int CNT_W = $clog2(2 * CLKS_PER_BIT) + 1;

    logic [DATA_W-1:0] mem_r [2**IDX_W];

    logic [2:0]       state_r,      nxt_state_s;
    logic [SR_W-1:0]  sr_r,         nxt_sr_s;
    logic [BIT_W-1:0] bit_cnt_r,    nxt_bit_cnt_s;
    logic [IDX_W-1:0] byte_idx_r,   nxt_byte_idx_s;
    logic [IDX_W-1:0] byte_idx_inc_s;
    logic [CNT_W-1:0] clk_cnt_r;
    logic [LEN_W-1:0] byte_count_r;
    logic [LEN_W-1:0] len_r;
    logic             test_r;
    logic             tx_line_r;
    logic             busy_r;
    logic             done_r;

    logic             wr_s;
    logic             start_ok_s;
    logic             bit_end_s;
    logic             last_bit_s;
    logic             launch_s;
    logic             tx_next_s;
    logic             crc_en_s;
    logic             crc_init_s;
    logic [CRC_W-1:0] crc_s;
    logic [CRC_W-1:0] crc_tx_s;

    function automatic logic [SR_W-1:0] align_byte(input logic [DATA_W-1:0] b);
        align_byte = SR_W'(b) << (SR_W - DATA_W);
    endfunction

    assign in_ready       = (state_r == ST_IDLE) && (byte_count_r < LEN_W'(MAX_BYTES));
    assign wr_s           = in_valid && in_ready;
    assign start_ok_s     = (state_r == ST_IDLE) && start && (byte_count_r != {LEN_W{1'b0}});
    assign bit_end_s      = (clk_cnt_r == CNT_W'(CLKS_PER_BIT - 1));
    assign last_bit_s     = (state_r == ST_CRC) ? (bit_cnt_r == BIT_W'(CRC_W - 1))
                                                : (bit_cnt_r == BIT_W'(7));
    assign byte_idx_inc_s = byte_idx_r + IDX_W'(1);
    assign crc_tx_s       = crc_s ^ CRC_W'(test_r);

    // Frame sequencing: decide the next field/bit at each bit boundary.
    always_comb begin
        nxt_state_s    = state_r;
        nxt_sr_s       = sr_r;
        nxt_bit_cnt_s  = bit_cnt_r;
        nxt_byte_idx_s = byte_idx_r;
        launch_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    launch_s       = 1'b1;
                    nxt_state_s    = ST_PRE;
                    nxt_sr_s       = align_byte(PREAMBLE);
                    nxt_bit_cnt_s  = {BIT_W{1'b0}};
                    nxt_byte_idx_s = {IDX_W{1'b0}};
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_PRE, ST_LEN, ST_DATA, ST_CRC: begin
                if (bit_end_s) begin
                    launch_s = 1'b1;
                    if (!last_bit_s) begin
                        nxt_sr_s      = sr_r << 1;
                        nxt_bit_cnt_s = bit_cnt_r + BIT_W'(1);
                    end else begin
                        nxt_bit_cnt_s = {BIT_W{1'b0}};
                        if (state_r == ST_PRE) begin
                            nxt_state_s = ST_LEN;
                            nxt_sr_s    = align_byte(len_r);
                        end else if (state_r == ST_LEN) begin
                            nxt_state_s    = ST_DATA;
                            nxt_byte_idx_s = {IDX_W{1'b0}};
                            nxt_sr_s       = align_byte(mem_r[IDX_W'(0)]);
                        end else if (state_r == ST_DATA) begin
                            // Last payload byte: the index wraps and the CRC follows.
                            if (LEN_W'(byte_idx_r) == (len_r - 8'd1)) begin
                                nxt_state_s    = ST_CRC;
                                nxt_byte_idx_s = {IDX_W{1'b0}};
                                nxt_sr_s       = SR_W'(crc_tx_s) << (SR_W - CRC_W);
                            end else begin
                                nxt_byte_idx_s = byte_idx_inc_s;
                                nxt_sr_s       = align_byte(mem_r[byte_idx_inc_s]);
                            end
                        end else begin
                            nxt_state_s = ST_STOP;
                        end
                    end
                end else begin
                    nxt_state_s = state_r;
                end
            end
            ST_STOP: begin
                if (clk_cnt_r == CNT_W'(2 * CLKS_PER_BIT - 1)) begin
                    nxt_state_s = ST_IDLE;
                end else begin
                    nxt_state_s = ST_STOP;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
    end

    // Line value for the next cycle; high whenever no field is being sent.
    always_comb begin
        if ((nxt_state_s == ST_PRE) || (nxt_state_s == ST_LEN) ||
            (nxt_state_s == ST_DATA) || (nxt_state_s == ST_CRC)) begin
            tx_next_s = nxt_sr_s[SR_W-1];
        end else begin
            tx_next_s = 1'b1;
        end
    end

    // The CRC absorbs each LEN/DATA bit as it is launched; seed on entry to LEN.
    assign crc_en_s   = launch_s && ((nxt_state_s == ST_LEN) || (nxt_state_s == ST_DATA));
    assign crc_init_s = launch_s && (state_r == ST_PRE) && (nxt_state_s == ST_LEN);

    crc_serial #(
        .CRC_W (CRC_W),
        .POLY  (CRC_POLY),
        .INIT  (CRC_INIT)
    ) u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init_s),
        .en    (crc_en_s),
        .din   (tx_next_s),
        .crc   (crc_s)
    );

    // Payload storage; emptiness is tracked by byte_count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[byte_count_r[IDX_W-1:0]] <= in_data;
        end
    end

    // Sequencer and serialiser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sr_r       <= {SR_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            byte_idx_r <= {IDX_W{1'b0}};
            clk_cnt_r  <= {CNT_W{1'b0}};
            tx_line_r  <= 1'b1;
        end else begin
            state_r    <= nxt_state_s;
            sr_r       <= nxt_sr_s;
            bit_cnt_r  <= nxt_bit_cnt_s;
            byte_idx_r <= nxt_byte_idx_s;
            tx_line_r  <= tx_next_s;
            if (launch_s || (nxt_state_s != state_r)) begin
                clk_cnt_r <= {CNT_W{1'b0}};
            end else if (state_r != ST_IDLE) begin
                clk_cnt_r <= clk_cnt_r + CNT_W'(1);
            end else begin
                clk_cnt_r <= clk_cnt_r;
            end
        end
    end

    // Buffer fill level, frame length/test capture and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count_r <= {LEN_W{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            test_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if ((state_r == ST_STOP) && (nxt_state_s == ST_IDLE)) begin
                byte_count_r <= {LEN_W{1'b0}};
            end else if (wr_s) begin
                byte_count_r <= byte_count_r + 8'd1;
            end else begin
                byte_count_r <= byte_count_r;
            end
            // A byte written in the start cycle joins the frame.
            if (start_ok_s) begin
                len_r  <= byte_count_r + (wr_s ? 8'd1 : 8'd0);
                test_r <= test_mode;
            end else begin
                len_r  <= len_r;
                test_r <= test_r;
            end
            busy_r <= (nxt_state_s != ST_IDLE);
            done_r <= (state_r == ST_STOP) && (clk_cnt_r == CNT_W'(2 * CLKS_PER_BIT - 2));
        end
    end

    assign tx_line    = tx_line_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign byte_count = byte_count_r;

endmodule
